coef_bank_ctrl: RTL

COEF_BANK_CTRL -- requirements
Module: coef_bank_ctrl

---
 rtl/coef_bank_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/coef_bank_ctrl.sv
// coef_bank_ctrl: double-buffered coefficient bank controller.
// A framed load stream fills the shadow bank. A complete frame is committed by
// flipping the bank select, but only while the datapath is not mid-sample
// (hold low). Malformed frames are reported and never committed.
// Optional feature: define COEF_BANK_CTRL_ERR_CNT_EN to add the saturating
// 8-bit err_cnt output that counts err_len pulses.
//
// Handshake: a beat transfers on a rising edge where s_coef_valid and
// s_coef_ready are both high. s_coef_ready depends only on the registered
// state, never on s_coef_valid.
module coef_bank_ctrl #(
  parameter int NCOEF = 6,
  parameter int COEFW = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [COEFW-1:0] s_coef_data,
  input  logic             s_coef_valid,
  input  logic             s_coef_last,
  output logic             s_coef_ready,
  input  logic             hold,
  output logic [COEFW-1:0] c [NCOEF],
  output logic             swapped,
  output logic             err_len,
  output logic             busy
`ifdef COEF_BANK_CTRL_ERR_CNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  localparam int IW = (NCOEF > 1) ? $clog2(NCOEF) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCOEF - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    PEND  = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_sel;
  logic [IW-1:0]    r_idx;
  logic [COEFW-1:0] r_bank [2][NCOEF];
  logic             r_swapped;
  logic             r_err_len;

  logic             w_xfer;
  logic             w_shadow;

  assign s_coef_ready = (r_state != PEND);
  assign busy         = (r_state != IDLE);
  assign swapped      = r_swapped;
  assign err_len      = r_err_len;
  assign w_xfer       = s_coef_valid & s_coef_ready;
  assign w_shadow     = ~r_sel;

  // Drive the active bank straight from the selected register bank.
  always_comb begin
    for (int i = 0; i < NCOEF; i++) begin
      c[i] = r_bank[r_sel][i];
    end
  end

  // Load/commit state machine; loads only ever touch the shadow bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_sel     <= 1'b0;
      r_idx     <= '0;
      r_swapped <= 1'b0;
      r_err_len <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NCOEF; i++) begin
          r_bank[b][i] <= '0;
        end
      end
    end else begin
      r_swapped <= 1'b0;
      r_err_len <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_bank[w_shadow][0] <= s_coef_data;
            if (s_coef_last) begin
              if (NCOEF == 1) begin
                r_state <= PEND;
              end else begin
                r_err_len <= 1'b1;
              end
            end else if (NCOEF == 1) begin
              // Single-coefficient frame ran past its only slot.
              r_err_len <= 1'b1;
              r_state   <= DRAIN;
            end else begin
              r_idx   <= IW'(1);
              r_state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (w_xfer) begin
            r_bank[w_shadow][r_idx] <= s_coef_data;
            if (s_coef_last) begin
              r_idx <= '0;
              if (r_idx == LAST_IDX) begin
                r_state <= PEND;
              end else begin
                // Short frame: the partial shadow contents are never committed.
                r_err_len <= 1'b1;
                r_state   <= IDLE;
              end
            end else if (r_idx == LAST_IDX) begin
              r_err_len <= 1'b1;
              r_state   <= DRAIN;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        DRAIN: begin
          // Swallow the rest of an overlong frame without writing anything.
          if (w_xfer && s_coef_last) begin
            r_idx   <= '0;
            r_state <= IDLE;
          end
        end
        PEND: begin
          if (!hold) begin
            r_sel     <= ~r_sel;
            r_swapped <= 1'b1;
            r_idx     <= '0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_idx   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef COEF_BANK_CTRL_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  // Count malformed-frame pulses, sticking at the top value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_cnt <= '0;
    end else if (r_err_len && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule
